sram_2p_bm_mbist: RTL
=====================

SRAM_2P_BM_MBIST -- requirements
Module: sram_2p_bm_mbist

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 32: word width in bits.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 8: address width in bits.
REQ-003 SHALL have parameter P_ADDR_COUNT, default 2**P_ADDR_WIDTH: number of words.
REQ-004 SHALL have parameter P_FORCE_ERROR, default 0: when 1, bit P_ERROR_BIT of word P_ERROR_ADDR reads stuck-at-0 on both ports.
REQ-005 SHALL have parameters P_ERROR_ADDR, default 50, and P_ERROR_BIT, default 0: location of the injected fault.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: CLK and RESET_N.
REQ-007 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-008 RESET_N  input  1  asynchronous active-low reset.
REQ-009 A_MEN / B_MEN  input  1  port enable.
REQ-010 A_WEN / B_WEN  input  1  write enable, qualified by xMEN.
REQ-011 A_REN / B_REN  input  1  read enable, qualified by xMEN.
REQ-012 A_ADDR / B_ADDR  input  P_ADDR_WIDTH  word address.
REQ-013 A_DIN / B_DIN  input  P_DATA_WIDTH  write data.
REQ-014 A_BM / B_BM  input  P_DATA_WIDTH  per-bit write mask, 1 = write the bit.
REQ-015 A_DOUT / B_DOUT  output  P_DATA_WIDTH  registered read data.
REQ-016 BIST_START  input  1  single-cycle request to start the March C- run.
REQ-017 BIST_BUSY  output  1  March run in progress.
REQ-018 BIST_DONE  output  1  run complete; sticky until the next accepted start.
REQ-019 BIST_FAIL  output  1  at least one miscompare; sticky until the next accepted start.
REQ-020 BIST_FAIL_ADDR  output  P_ADDR_WIDTH  address of the first miscompare.
REQ-021 BIST_FAIL_ELEM  output  3  March element (0..5) of the first miscompare.
REQ-022 COLLISION  output  1  one-cycle pulse: both ports wrote the same address in the previous cycle.

Function
REQ-023 Write SHALL apply when xMEN=1 and xWEN=1: mem = (mem & ~xBM) | (xDIN & xBM).
REQ-024 Write with xREN=1 on the same port SHALL load xDOUT with the newly merged word on the same edge (write-through).
REQ-025 Read with xMEN=1, xREN=1, xWEN=0 SHALL load xDOUT with the stored word on the same edge (1-cycle latency).
REQ-026 If neither REQ-024 nor REQ-025 applies, xDOUT SHALL hold its value.
REQ-027 Port B reading an address port A writes in the same cycle SHALL return the old data (read-first), and symmetrically for port A.
REQ-028 Both ports writing the same address in one cycle: where the masks overlap, port B's bits SHALL win; all other bits merge per port; COLLISION=1 on the next cycle.
REQ-029 The FSM SHALL have states IDLE, RUN and CMP; BIST_START SHALL be accepted only in IDLE and ignored otherwise.
REQ-030 An accepted start SHALL clear DONE, FAIL, FAIL_ADDR and FAIL_ELEM, set BUSY, and enter RUN.
REQ-031 RUN SHALL issue one port-A operation per cycle over the March C- elements:
  - 0: any order, w0
  - 1: ascending, r0,w1
  - 2: ascending, r1,w0
  - 3: descending, r0,w1
  - 4: descending, r1,w0
  - 5: any order (ascending used), r0
  "0/1" = all-zeros/all-ones word with full mask. Total 10*P_ADDR_COUNT operations.
REQ-032 Each BIST read SHALL be compared one cycle after issue; the first miscompare latches FAIL_ADDR and FAIL_ELEM, later miscompares only keep FAIL=1.
REQ-033 Address counters SHALL wrap P_ADDR_COUNT-1→0 ascending and 0→P_ADDR_COUNT-1 descending, and advance the element at wrap.
REQ-034 The last operation SHALL go RUN→CMP; CMP SHALL, one cycle later, assert DONE, deassert BUSY, and go to IDLE.
REQ-035 With START accepted at edge 0, DONE SHALL rise at edge 10*P_ADDR_COUNT+1.
REQ-036 While BUSY=1, all functional port inputs SHALL be ignored, A_DOUT and B_DOUT SHALL hold, and COLLISION SHALL remain 0.
REQ-037 Memory contents after a run SHALL be all zeros.

Reset
REQ-038 RESET_N=0 SHALL immediately force A_DOUT=0, B_DOUT=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_ELEM=0, COLLISION=0, and FSM=IDLE.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset during RUN or CMP SHALL abort the run with no DONE pulse.

Verification
REQ-041 A writes 0xFFFF_FFFF to addr 3, then A writes 0x0000_0000 with BM=0x0000_FF00, then A reads addr 3 → A_DOUT=0xFFFF_00FF one cycle later.
REQ-042 Same cycle: A writes DIN=0xAAAA_AAAA, BM=0xFFFF_0000 and B writes DIN=0x5555_5555, BM=0x00FF_FF00, both to addr 7 → word=0xAA55_5500 over an initial 0, COLLISION=1 for exactly one cycle.
REQ-043 P_ADDR_WIDTH=4, pulse START → BUSY=1, DONE=1 at edge 161, FAIL=0, all 16 words read 0.
REQ-044 P_FORCE_ERROR=1, P_ERROR_ADDR=50, P_ERROR_BIT=0, default widths → FAIL=1, FAIL_ADDR=50, FAIL_ELEM=2.
REQ-045 Deassert RESET_N at run cycle 40, then release → all flags 0, IDLE; a new START then completes normally.
REQ-046 START pulsed while BUSY=1 → ignored, DONE timing unchanged; functional port writes during BUSY leave memory unaffected.

Source files
------------

// File: rtl/sram_2p_bm_mbist_if.sv
// Signal bundle for the two-port bit-masked SRAM and its March C- self-test controller.
interface sram_2p_bm_mbist_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 8
);
    logic                    A_MEN;
    logic                    A_WEN;
    logic                    A_REN;
    logic [P_ADDR_WIDTH-1:0] A_ADDR;
    logic [P_DATA_WIDTH-1:0] A_DIN;
    logic [P_DATA_WIDTH-1:0] A_BM;
    logic [P_DATA_WIDTH-1:0] A_DOUT;
    logic                    B_MEN;
    logic                    B_WEN;
    logic                    B_REN;
    logic [P_ADDR_WIDTH-1:0] B_ADDR;
    logic [P_DATA_WIDTH-1:0] B_DIN;
    logic [P_DATA_WIDTH-1:0] B_BM;
    logic [P_DATA_WIDTH-1:0] B_DOUT;
    logic                    BIST_START;
    logic                    BIST_BUSY;
    logic                    BIST_DONE;
    logic                    BIST_FAIL;
    logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR;
    logic [2:0]              BIST_FAIL_ELEM;
    logic                    COLLISION;

    modport master (
        output A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM,
        output B_MEN, B_WEN, B_REN, B_ADDR, B_DIN, B_BM,
        output BIST_START,
        input  A_DOUT, B_DOUT, BIST_BUSY, BIST_DONE, BIST_FAIL,
        input  BIST_FAIL_ADDR, BIST_FAIL_ELEM, COLLISION
    );

    modport slave (
        input  A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM,
        input  B_MEN, B_WEN, B_REN, B_ADDR, B_DIN, B_BM,
        input  BIST_START,
        output A_DOUT, B_DOUT, BIST_BUSY, BIST_DONE, BIST_FAIL,
        output BIST_FAIL_ADDR, BIST_FAIL_ELEM, COLLISION
    );
endinterface

// File: rtl/sram_2p_bm_mbist.sv
// Two-port SRAM with per-bit write masks, read-first cross-port behaviour, port-B-wins
// collision merging, and a built-in March C- tester that owns port A while busy.
module sram_2p_bm_mbist #(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_ADDR_WIDTH  = 8,
    parameter int P_ADDR_COUNT  = 2**P_ADDR_WIDTH,
    parameter int P_FORCE_ERROR = 0,
    parameter int P_ERROR_ADDR  = 50,
    parameter int P_ERROR_BIT   = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    sram_2p_bm_mbist_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CMP = 2'd2} state_t;

    localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_ZERO = {P_ADDR_WIDTH{1'b0}};
    localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_ADDR_WIDTH-1:0] L_LAST      = P_ADDR_WIDTH'(P_ADDR_COUNT - 1);
    localparam logic [P_ADDR_WIDTH-1:0] L_ERR_ADDR  = P_ADDR_WIDTH'(P_ERROR_ADDR);
    localparam logic [P_DATA_WIDTH-1:0] L_ZEROS     = {P_DATA_WIDTH{1'b0}};
    localparam logic [P_DATA_WIDTH-1:0] L_ONES      = {P_DATA_WIDTH{1'b1}};

    // The injected fault models a cell stuck at 0, so it shows on every read path.
    function automatic logic [P_DATA_WIDTH-1:0] apply_fault(
        input logic [P_ADDR_WIDTH-1:0] addr,
        input logic [P_DATA_WIDTH-1:0] word
    );
        logic [P_DATA_WIDTH-1:0] w;
        w = word;
        if ((P_FORCE_ERROR == 1) && (addr == L_ERR_ADDR)) begin
            w[P_ERROR_BIT] = 1'b0;
        end
        return w;
    endfunction

    logic [P_DATA_WIDTH-1:0] mem_q [P_ADDR_COUNT];

    state_t                  state_q;
    logic                    busy_q, done_q, fail_q, phase_q, cmp_valid_q, collision_q;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q, addr_q, cmp_addr_q;
    logic [2:0]              fail_elem_q, elem_q, cmp_elem_q;
    logic [P_DATA_WIDTH-1:0] cmp_exp_q, rdata_q, a_dout_q, b_dout_q;

    logic                    op_rd_s, op_wr_s, op_ones_s, desc_s, two_op_s;
    logic                    run_s, bist_rd_s, bist_wr_s, addr_end_s, op_end_s, miscmp_s;
    logic                    a_wr_s, b_wr_s, a_rd_s, b_rd_s, same_s;
    logic [P_ADDR_WIDTH-1:0] a_addr_s;
    logic [P_DATA_WIDTH-1:0] op_word_s, a_din_s, a_bm_s, a_old_s, b_old_s;
    logic [P_DATA_WIDTH-1:0] a_merge_s, b_base_s, b_merge_s;

    // Decode the March C- operation for the current element and phase.
    always_comb begin
        op_rd_s   = 1'b0;
        op_wr_s   = 1'b0;
        op_ones_s = 1'b0;
        desc_s    = 1'b0;
        two_op_s  = 1'b1;
        case (elem_q)
            3'd0: begin op_wr_s = 1'b1; two_op_s = 1'b0; end
            3'd1: begin op_rd_s = ~phase_q; op_wr_s = phase_q; op_ones_s = phase_q; end
            3'd2: begin op_rd_s = ~phase_q; op_wr_s = phase_q; op_ones_s = ~phase_q; end
            3'd3: begin op_rd_s = ~phase_q; op_wr_s = phase_q; op_ones_s = phase_q; desc_s = 1'b1; end
            3'd4: begin op_rd_s = ~phase_q; op_wr_s = phase_q; op_ones_s = ~phase_q; desc_s = 1'b1; end
            3'd5: begin op_rd_s = 1'b1; two_op_s = 1'b0; end
            default: begin two_op_s = 1'b0; end
        endcase
    end

    assign run_s      = (state_q == RUN);
    assign bist_rd_s  = run_s & op_rd_s;
    assign bist_wr_s  = run_s & op_wr_s;
    assign op_word_s  = op_ones_s ? L_ONES : L_ZEROS;
    assign addr_end_s = desc_s ? (addr_q == L_ADDR_ZERO) : (addr_q == L_LAST);
    assign op_end_s   = ~two_op_s | phase_q;
    assign miscmp_s   = cmp_valid_q & (rdata_q != cmp_exp_q);

    // While busy the tester owns port A and port B is shut off entirely.
    assign a_wr_s   = busy_q ? bist_wr_s : (bus.A_MEN & bus.A_WEN);
    assign a_rd_s   = ~busy_q & bus.A_MEN & bus.A_REN;
    assign b_wr_s   = ~busy_q & bus.B_MEN & bus.B_WEN;
    assign b_rd_s   = ~busy_q & bus.B_MEN & bus.B_REN;
    assign a_addr_s = busy_q ? addr_q : bus.A_ADDR;
    assign a_din_s  = busy_q ? op_word_s : bus.A_DIN;
    assign a_bm_s   = busy_q ? L_ONES : bus.A_BM;

    assign a_old_s   = mem_q[a_addr_s];
    assign b_old_s   = mem_q[bus.B_ADDR];
    assign a_merge_s = (a_old_s & ~a_bm_s) | (a_din_s & a_bm_s);
    assign same_s    = a_wr_s & b_wr_s & (a_addr_s == bus.B_ADDR);
    // On a same-address double write B merges on top of A's result, so B wins overlaps.
    assign b_base_s  = same_s ? a_merge_s : b_old_s;
    assign b_merge_s = (b_base_s & ~bus.B_BM) | (bus.B_DIN & bus.B_BM);

    // Storage array; contents survive reset.
    always_ff @(posedge CLK) begin
        if (a_wr_s) mem_q[a_addr_s] <= a_merge_s;
        if (b_wr_s) mem_q[bus.B_ADDR] <= b_merge_s;
    end

    // Functional read-data registers and the collision pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_dout_q    <= L_ZEROS;
            b_dout_q    <= L_ZEROS;
            collision_q <= 1'b0;
        end else begin
            if (a_rd_s) a_dout_q <= apply_fault(a_addr_s, a_wr_s ? a_merge_s : a_old_s);
            if (b_rd_s) b_dout_q <= apply_fault(bus.B_ADDR, b_wr_s ? b_merge_s : b_old_s);
            collision_q <= same_s;
        end
    end

    // BIST sequencer, one-cycle read-compare pipeline and sticky result flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= L_ADDR_ZERO;
            fail_elem_q <= 3'd0;
            elem_q      <= 3'd0;
            addr_q      <= L_ADDR_ZERO;
            phase_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= L_ZEROS;
            cmp_addr_q  <= L_ADDR_ZERO;
            cmp_elem_q  <= 3'd0;
            rdata_q     <= L_ZEROS;
        end else begin
            cmp_valid_q <= bist_rd_s;
            if (bist_rd_s) begin
                rdata_q    <= apply_fault(addr_q, a_old_s);
                cmp_exp_q  <= op_word_s;
                cmp_addr_q <= addr_q;
                cmp_elem_q <= elem_q;
            end
            case (state_q)
                IDLE: begin
                    if (bus.BIST_START) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= L_ADDR_ZERO;
                        fail_elem_q <= 3'd0;
                        elem_q      <= 3'd0;
                        addr_q      <= L_ADDR_ZERO;
                        phase_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!op_end_s) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (!addr_end_s) begin
                            addr_q <= desc_s ? (addr_q - L_ADDR_ONE) : (addr_q + L_ADDR_ONE);
                        end else if (elem_q == 3'd5) begin
                            state_q <= CMP;
                        end else begin
                            elem_q <= elem_q + 3'd1;
                            // Elements 3 and 4 walk downwards from the top address.
                            addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? L_LAST : L_ADDR_ZERO;
                        end
                    end
                end
                CMP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (miscmp_s) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= cmp_addr_q;
                    fail_elem_q <= cmp_elem_q;
                end
            end
        end
    end

    assign bus.A_DOUT         = a_dout_q;
    assign bus.B_DOUT         = b_dout_q;
    assign bus.BIST_BUSY      = busy_q;
    assign bus.BIST_DONE      = done_q;
    assign bus.BIST_FAIL      = fail_q;
    assign bus.BIST_FAIL_ADDR = fail_addr_q;
    assign bus.BIST_FAIL_ELEM = fail_elem_q;
    assign bus.COLLISION      = collision_q;
endmodule
